// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and edge-detect the DE1 keys,
// with optional auto-repeat press pulses for held movement buttons.
module button_conditioner #(
    parameter int                 NUM_BTN    = 4,
    parameter int                 DB_CYCLES  = 500000,
    parameter int                 RPT_DELAY  = 15000000,
    parameter int                 RPT_PERIOD = 5000000,
    parameter logic [NUM_BTN-1:0] RPT_MASK   = 4'b0011
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] key_n,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);
    localparam int DB_W    = $clog2(DB_CYCLES);
    localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY
                                                      : RPT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    localparam logic [DB_W-1:0]  DB_TC  = DB_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] DLY_TC = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_TC = RPT_W'(RPT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rpt_state_t;

    logic [NUM_BTN-1:0] sync_q1;
    logic [NUM_BTN-1:0] sync_q2;
    logic [NUM_BTN-1:0] raw_pressed;

    // two-flop synchroniser; resets to the released (high) level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= key_n;
            sync_q2 <= sync_q1;
        end
    end

    assign raw_pressed = ~sync_q2;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic [DB_W-1:0]  db_cnt;
        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             differ;
        logic             db_done;
        logic             rise;
        logic             fall;
        rpt_state_t       rpt_state;
        rpt_state_t       rpt_state_nxt;
        logic [RPT_W-1:0] rpt_cnt;
        logic [RPT_W-1:0] rpt_cnt_nxt;
        logic             rpt_fire;

        assign differ  = raw_pressed[i] ^ level_q;
        assign db_done = differ && (db_cnt == DB_TC);
        assign rise    = db_done && !level_q;
        assign fall    = db_done && level_q;

        // debounce counter: any cycle of agreement restarts the count
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                db_cnt <= '0;
            end else if (!differ || db_done) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end

        // accepted level and registered edge pulses
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                level_q   <= level_q ^ db_done;
                press_q   <= rise | rpt_fire;
                release_q <= fall;
            end
        end

        // auto-repeat state register
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rpt_state <= IDLE;
                rpt_cnt   <= '0;
            end else begin
                rpt_state <= rpt_state_nxt;
                rpt_cnt   <= rpt_cnt_nxt;
            end
        end

        // repeat sequencing; a coinciding release suppresses the pulse
        always_comb begin
            rpt_state_nxt = rpt_state;
            rpt_cnt_nxt   = rpt_cnt;
            rpt_fire      = 1'b0;
            unique case (rpt_state)
                IDLE: begin
                    if (RPT_MASK[i] && rise) begin
                        rpt_state_nxt = DELAY;
                        rpt_cnt_nxt   = '0;
                    end
                end
                DELAY: begin
                    if (fall) begin
                        rpt_state_nxt = IDLE;
                        rpt_cnt_nxt   = '0;
                    end else if (rpt_cnt == DLY_TC) begin
                        rpt_fire      = 1'b1;
                        rpt_state_nxt = REPEAT;
                        rpt_cnt_nxt   = '0;
                    end else begin
                        rpt_cnt_nxt = rpt_cnt + RPT_W'(1);
                    end
                end
                REPEAT: begin
                    if (fall) begin
                        rpt_state_nxt = IDLE;
                        rpt_cnt_nxt   = '0;
                    end else if (rpt_cnt == PER_TC) begin
                        rpt_fire    = 1'b1;
                        rpt_cnt_nxt = '0;
                    end else begin
                        rpt_cnt_nxt = rpt_cnt + RPT_W'(1);
                    end
                end
                default: begin
                    rpt_state_nxt = IDLE;
                    rpt_cnt_nxt   = '0;
                end
            endcase
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the raw DE1 push-buttons before they reach the game FSM and game logic; sits between the KEY pins and the start/fire/left/right nets in the top level.
- Per button: 2-flop synchroniser, counter-based debouncer, and press/release edge pulses.
- Left/right movement buttons can also generate auto-repeat press pulses while held.
- Outputs are active-high and registered, so downstream logic drops its own inversion of KEY.

Parameters:
- NUM_BTN, 4, number of buttons conditioned; bit i of every bus refers to button i.
- DB_CYCLES, 500000, clocks of continuous changed level needed to accept a transition (10 ms at 50 MHz); legal range ≥ 2.
- RPT_DELAY, 15000000, clocks from the initial press pulse to the first repeat pulse (300 ms).
- RPT_PERIOD, 5000000, clocks between subsequent repeat pulses (100 ms).
- RPT_MASK, 4'b0011, per-button auto-repeat enable; default enables KEY[0] (right) and KEY[1] (left).

Ports:
- clk, input, 1, game clock (50 MHz), the only clock.
- reset_n, input, 1, asynchronous active-low reset.
- key_n, input, NUM_BTN, raw push-buttons, active-low, asynchronous to clk.
- btn_level, output, NUM_BTN, debounced pressed state, 1 = held.
- btn_press, output, NUM_BTN, one-cycle pulse on accepted press, plus on each auto-repeat.
- btn_release, output, NUM_BTN, one-cycle pulse on accepted release.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - While reset_n = 0:
    - synchroniser flops are forced to 1 (released);
    - btn_level, btn_press and btn_release are forced to 0;
    - all debounce and repeat counters are forced to 0.
  - Reset asserted mid-debounce or mid-repeat abandons that operation; no pulse is emitted on reset release.
- Synchroniser:
  - key_n passes through 2 flops; s[i] is the second flop output.
  - s[i] is inverted to give raw_pressed[i].
- Debounce, per button, counter width $clog2(DB_CYCLES):
  - If raw_pressed[i] == btn_level[i], the counter clears to 0.
  - Otherwise the counter increments.
  - On the edge where the counter equals DB_CYCLES-1 and the levels still differ:
    - btn_level[i] toggles;
    - the counter clears.
  - Any single-cycle agreement during counting restarts the count from 0 (glitch rejection).
- Latency:
  - key_n held low from clock edge E gives btn_level rising on edge E+DB_CYCLES+2.
  - Release behaves symmetrically.
- Edge pulses, registered:
  - btn_press[i] = 1 for exactly the cycle in which btn_level[i] goes 0→1.
  - btn_release[i] = 1 for exactly the cycle in which btn_level[i] goes 1→0.
- Auto-repeat, only for buttons with RPT_MASK[i] = 1; counter width $clog2(max(RPT_DELAY, RPT_PERIOD)):
  - State IDLE:
    - btn_level 0→1 moves to DELAY with counter = 0.
  - State DELAY:
    - counter increments each cycle.
    - On counter == RPT_DELAY-1: pulse btn_press, clear counter, go to REPEAT.
  - State REPEAT:
    - counter increments each cycle.
    - On counter == RPT_PERIOD-1: pulse btn_press and clear counter.
  - Accepted release (btn_level 1→0) from DELAY or REPEAT returns to IDLE, clears the counter and emits no further press pulses.
  - If the release edge coincides with a repeat terminal count, the release wins: btn_release = 1 and btn_press = 0 in that cycle.
  - Buttons with RPT_MASK[i] = 0 stay in IDLE; exactly one press pulse per hold.
- Independence:
  - Buttons are fully independent.
  - Simultaneous presses on several buttons produce simultaneous pulses.
- No combinational path from key_n to any output.

Test Plan:
- Reset defaults: reset_n = 0 with key_n = 4'b0000 for 10 cycles, then release reset with keys still low → all outputs 0 during reset; btn_level = 4'b1111 exactly DB_CYCLES+2 edges after reset release.
  - Use DB_CYCLES = 8, RPT_DELAY = 20, RPT_PERIOD = 5 for all scenarios.
- Clean press/release on button 2:
  - key_n[2] low for 30 cycles → btn_level[2] rises at edge 10 with a single btn_press[2] pulse in the same cycle.
  - Then key_n[2] high → btn_release[2] pulse 10 edges later.
  - No repeat pulses on button 2 (mask bit 0).
- Glitch rejection: key_n[3] low for 7 cycles, high 1 cycle, low 7 cycles, high → btn_level[3] stays 0; no pulses.
- Auto-repeat on button 0: key_n[0] held low for 60 cycles → press pulses at cycle 10, 30, 35, 40, 45, …; no pulses after the accepted release.
- Release/repeat collision: arrange the release acceptance on the same edge as a repeat terminal count on button 1 → btn_release[1] = 1, btn_press[1] = 0 that cycle, state returns to IDLE.
- Mid-operation reset: assert reset_n while button 0 is in REPEAT → outputs 0 immediately (asynchronous); after deassertion with the key still held, a fresh press occurs DB_CYCLES+2 edges later.
